// File: rtl/logic_avalon_st_to_axi4_stream_if.sv
// rtl/logic_avalon_st_to_axi4_stream_if.sv - Avalon-ST and AXI4-Stream bus interfaces for the bridge

// Avalon-ST bus; rx is the sink view, tx the source view
interface logic_avalon_st_if #(
  parameter int DATA_BYTES    = 1,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = 1,
  parameter int ERROR_WIDTH   = 1
);
  logic                     valid;
  logic                     ready;
  logic [8*DATA_BYTES-1:0]  data;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [ERROR_WIDTH-1:0]   error;

  modport rx (
    input  valid, data, channel, startofpacket, endofpacket, empty, error,
    output ready
  );

  modport tx (
    output valid, data, channel, startofpacket, endofpacket, empty, error,
    input  ready
  );
endinterface

// AXI4-Stream bus; tx is the master view, rx the slave view
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [8*TDATA_BYTES-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport tx (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport rx (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/logic_avalon_st_to_axi4_stream.sv
// rtl/logic_avalon_st_to_axi4_stream.sv - Avalon-ST sink to AXI4-Stream master bridge with credit-tracked FIFO

module logic_avalon_st_to_axi4_stream #(
  parameter int TDATA_BYTES                     = 1,
  parameter int TDEST_WIDTH                     = 1,
  parameter int TUSER_WIDTH                     = 1,
  parameter int TID_WIDTH                       = 1,
  parameter int USE_TLAST                       = 1,
  parameter int USE_TKEEP                       = 1,
  parameter int USE_TSTRB                       = 1,
  parameter int EMPTY_WIDTH                     = (TDATA_BYTES >= 2) ? $clog2(TDATA_BYTES) : 1,
  parameter int FIRST_SYMBOL_IN_HIGH_ORDER_BITS = 1,
  parameter int READY_LATENCY                   = 0,
  parameter int FIFO_DEPTH                      = READY_LATENCY + 2
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  logic_avalon_st_if.rx        rx,
  logic_axi4_stream_if.tx      tx
);

  localparam int DATA_W = 8 * TDATA_BYTES;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0]      tdata;
    logic [TDATA_BYTES-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TUSER_WIDTH-1:0] tuser;
  } entry_t;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             in_packet_q, in_packet_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];

  logic [CNT_W-1:0] pending;
  logic [CNT_W:0]   occupancy;
  logic             rx_ready;
  logic             credit;
  logic             wr_en;
  logic             rd_en;
  logic             tx_valid;
  entry_t           wr_entry;
  entry_t           rd_entry;

  // Ready only counts beats already stored plus beats we have granted but not yet seen
  assign occupancy = {1'b0, count_q} + {1'b0, pending};
  assign rx_ready  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign rx.ready  = rx_ready;

  generate
    if (READY_LATENCY > 0) begin : g_hist
      logic [READY_LATENCY-1:0] ready_hist_q, ready_hist_d;

      // Shift the ready we present now; the oldest bit grants the beat arriving this cycle
      always_comb begin
        ready_hist_d    = '0;
        ready_hist_d[0] = rx_ready;
        for (int i = 1; i < READY_LATENCY; i++) begin
          ready_hist_d[i] = ready_hist_q[i-1];
        end
        pending = '0;
        for (int i = 0; i < READY_LATENCY; i++) begin
          pending = pending + CNT_W'(ready_hist_q[i]);
        end
      end

      // Ready history register
      always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
          ready_hist_q <= '0;
        end else begin
          ready_hist_q <= ready_hist_d;
        end
      end

      assign credit = ready_hist_q[READY_LATENCY-1];
    end else begin : g_no_hist
      assign pending = '0;
      assign credit  = rx_ready;
    end
  endgenerate

  // A beat without a matching credit is a source protocol violation and is dropped
  assign wr_en    = rx.valid && credit;
  assign tx_valid = (count_q != '0);
  assign rd_en    = tx_valid && tx.tready;

  // Convert the incoming Avalon beat into its AXI form and track packet framing
  always_comb begin
    int unsigned e;
    logic        bad_frame;
    wr_entry = '0;
    e        = 0;
    for (int k = 0; k < TDATA_BYTES; k++) begin
      if (FIRST_SYMBOL_IN_HIGH_ORDER_BITS != 0) begin
        wr_entry.tdata[8*k +: 8] = rx.data[8*(TDATA_BYTES-1-k) +: 8];
      end else begin
        wr_entry.tdata[8*k +: 8] = rx.data[8*k +: 8];
      end
    end
    if (rx.endofpacket) begin
      e = (32'(rx.empty) > 32'(TDATA_BYTES - 1)) ? 32'(TDATA_BYTES - 1) : 32'(rx.empty);
    end
    for (int k = 0; k < TDATA_BYTES; k++) begin
      wr_entry.tkeep[k] = (32'(k) + e) <= 32'(TDATA_BYTES - 1);
    end
    bad_frame         = (rx.startofpacket && in_packet_q) || (!rx.startofpacket && !in_packet_q);
    wr_entry.tlast    = rx.endofpacket;
    wr_entry.tid      = rx.channel;
    wr_entry.tuser[0] = (|rx.error) || bad_frame;

    in_packet_d = in_packet_q;
    if (wr_en) begin
      if (rx.endofpacket) begin
        in_packet_d = 1'b0;
      end else if (rx.startofpacket) begin
        in_packet_d = 1'b1;
      end
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; reset discards queued beats and drops tvalid immediately
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_packet_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_packet_q <= in_packet_d;
    end
  end

  // Payload storage carries no reset
  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

  // Head entry drives the master side and stays put until it is taken
  assign rd_entry  = mem_q[rd_ptr_q];
  assign tx.tvalid = tx_valid;
  assign tx.tdata  = rd_entry.tdata;
  assign tx.tkeep  = (USE_TKEEP != 0) ? rd_entry.tkeep : {TDATA_BYTES{1'b1}};
  // Avalon carries no position-byte information, so tstrb always mirrors tkeep
  assign tx.tstrb  = (USE_TSTRB != 0) ? tx.tkeep : tx.tkeep;
  assign tx.tlast  = (USE_TLAST != 0) ? rd_entry.tlast : 1'b1;
  assign tx.tid    = rd_entry.tid;
  assign tx.tdest  = {TDEST_WIDTH{1'b0}};
  assign tx.tuser  = rd_entry.tuser;

endmodule
